// File: rtl/simon_encrypt_core.sv
// -----------------------------------------------------------------------------
// simon_encrypt_core
//
// Iterative SIMON32/64 block encryption. The core executes one round per clock
// and expands the round keys on the fly from a sliding four-word key window.
// Only one block is processed at a time. Both sides use a valid/ready
// handshake.
//
// Ports:
//   clk         system clock; all state changes on the rising edge
//   rst         synchronous, active-high reset; discards any in-flight block
//   in_valid    plaintext and key are valid
//   in_ready    core is idle and can accept a block
//   plaintext   [31:16] = x (left word), [15:0] = y (right word)
//   key         [63:48]=k3, [47:32]=k2, [31:16]=k1, [15:0]=k0
//   out_valid   ciphertext is valid
//   out_ready   downstream accepts the ciphertext
//   ciphertext  {x, y} after ROUNDS rounds
//   busy        high while a block is in flight (RUN or DONE)
// -----------------------------------------------------------------------------
module simon_encrypt_core #(
  parameter int ROUNDS = 32,  // 32 for SIMON32/64; other values for debug only
  parameter int CW     = 5    // round counter width, 2**CW >= ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] plaintext,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ciphertext,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // z0 sequence with bit i = i-th element (bit 0 used first).
  localparam logic [31:0] Z0 = 32'hB386_A45F;

  state_t              state;
  state_t              state_next;
  logic [15:0]         x;
  logic [15:0]         y;
  logic [3:0][15:0]    kw;       // kw[0] is the key of the round being executed
  logic [CW-1:0]       rc;

  logic                last_round;
  logic [15:0]         f_x;
  logic [15:0]         x_next;
  logic [15:0]         t_rot;
  logic [15:0]         t_mix;
  logic [15:0]         knew;

  function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  // ---------------------------------------------------------------------------
  // Round function and key expansion (pure 16-bit logic, no carries)
  // ---------------------------------------------------------------------------
  assign last_round = (rc == CW'(ROUNDS - 1));

  assign f_x    = (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2);
  assign x_next = y ^ f_x ^ kw[0];

  // The window holds k[i..i+3]; the word computed here is k[i+4]. It is only
  // consumed from round 4 on, so the extra words produced near the end of a
  // block are simply discarded.
  assign t_rot = ror16(kw[3], 3) ^ kw[1];
  assign t_mix = t_rot ^ ror16(t_rot, 1);
  assign knew  = ~kw[0] ^ t_mix ^ {15'd0, Z0[rc]} ^ 16'h0003;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked processes use non-blocking assignments so every register
  // samples the pre-edge values of the others, which the round/key update
  // below depends on (y takes the old x while x is being overwritten).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_round) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: block, key window and round counter
  // ---------------------------------------------------------------------------
  // NOTE: the data and key-window registers are cleared on reset even though
  // they are always reloaded on accept; a reset core shows an all-zero
  // ciphertext rather than remnants of a discarded block.
  always_ff @(posedge clk) begin
    if (rst) begin
      x  <= '0;
      y  <= '0;
      kw <= '0;
      rc <= '0;
    end else if (state == IDLE && in_valid) begin
      x  <= plaintext[31:16];
      y  <= plaintext[15:0];
      kw <= key;
      rc <= '0;
    end else if (state == RUN) begin
      x  <= x_next;
      y  <= x;
      kw <= {knew, kw[3], kw[2], kw[1]};
      rc <= rc + CW'(1);
    end
  end

  // Held unchanged through DONE, so back-pressure needs no extra register.
  assign ciphertext = {x, y};

endmodule

// File: tb/tb_simon_encrypt_core.sv
// -----------------------------------------------------------------------------
// tb_simon_encrypt_core
//
// Self-checking bench for simon_encrypt_core: published reference vector,
// latency, back-pressure, busy-ignore, mid-run reset, back-to-back accepts and
// a short run of random vectors against a reference model written from the
// standard SIMON32/64 key-schedule formulation.
// -----------------------------------------------------------------------------
module tb_simon_encrypt_core;

  localparam logic [63:0] KEY1 = 64'h1918_1110_0908_0100;
  localparam logic [31:0] PT1  = 32'h6565_6877;
  localparam logic [31:0] CT1  = 32'hc69b_e9bb;
  localparam int          LAT  = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] plaintext;
  logic [63:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ciphertext;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor state
  int          cyc = 0;        // number of rising edges seen
  int          acc_cnt = 0;
  int          last_acc = 0;   // edge number of the latest accept
  int          out_cnt = 0;
  logic [31:0] out_q[$];

  simon_encrypt_core dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= cyc + 1;
    end
    if (!rst && out_valid && out_ready) begin
      out_cnt <= out_cnt + 1;
      out_q.push_back(ciphertext);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: explicit key array k[0..31], then 32 Feistel rounds.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic [31:0] simon_ref(input logic [63:0] k_in, input logic [31:0] p);
    string       z = "11111010001001010110000111001101";
    logic [15:0] k[32];
    logic [15:0] tmp;
    logic [15:0] xr;
    logic [15:0] yr;
    logic [15:0] zb;
    for (int i = 0; i < 4; i++) k[i] = k_in[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      tmp  = rotr(k[i-1], 3) ^ k[i-3];
      tmp  = tmp ^ rotr(tmp, 1);
      zb   = (z[i-4] == 8'h31) ? 16'd1 : 16'd0;
      k[i] = ~k[i-4] ^ tmp ^ zb ^ 16'h0003;
    end
    xr = p[31:16];
    yr = p[15:0];
    for (int i = 0; i < 32; i++) begin
      tmp = xr;
      xr  = yr ^ ((rotl(xr, 1) & rotl(xr, 8)) ^ rotl(xr, 2)) ^ k[i];
      yr  = tmp;
    end
    return {xr, yr};
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one block for exactly one rising edge.
  task automatic send(input string tag, input logic [63:0] k, input logic [31:0] p);
    check({tag, "_in_ready"}, in_ready, 1);
    key       = k;
    plaintext = p;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // Waits (bounded) for out_valid and checks latency from the latest accept.
  task automatic wait_valid(input string tag);
    int guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_latency"}, cyc - last_acc + 1, LAT);
  endtask

  // Waits (bounded) until the output handshake count reaches target.
  task automatic wait_out(input string tag, input int target, input bit rand_stall);
    int guard = 0;
    while (out_cnt < target && guard < 400) begin
      if (rand_stall) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b1;
    check({tag, "_out_seen"}, out_cnt, target);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] exp0;
    logic [63:0] rk;
    logic [31:0] rp;
    int          base;
    int          acc1;
    int          guard;

    rst       = 1'b1;
    in_valid  = 1'b0;
    plaintext = '0;
    key       = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready",   in_ready,   1);
    check("rst_out_valid",  out_valid,  0);
    check("rst_busy",       busy,       0);
    check("rst_ciphertext", ciphertext, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1. Reference vector
    send("t1", KEY1, PT1);
    check("t1_busy_run", busy, 1);
    wait_valid("t1");
    check("t1_ct", ciphertext, CT1);
    check("t1_busy_done", busy, 1);
    check("t1_in_ready_done", in_ready, 0);
    @(negedge clk);
    check("t1_out_valid_after", out_valid, 0);
    check("t1_in_ready_after",  in_ready,  1);
    check("t1_busy_after",      busy,      0);

    // 2. Back-pressure
    base      = out_cnt;
    out_ready = 1'b0;
    send("t2", KEY1, PT1);
    wait_valid("t2");
    for (int i = 0; i < 10; i++) begin
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_ct", ciphertext, CT1);
      @(negedge clk);
    end
    check("t2_no_early_out", out_cnt - base, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_released", out_valid, 0);
    repeat (3) @(negedge clk);
    check("t2_single_out", out_cnt - base, 1);
    check("t2_out_value", out_q[$], CT1);

    // 3. in_valid while busy is ignored
    base = acc_cnt;
    send("t3", KEY1, PT1);
    repeat (3) @(negedge clk);
    check("t3_in_ready_busy", in_ready, 0);
    plaintext = 32'h0000_0000;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    check("t3_single_accept", acc_cnt - base, 1);
    wait_valid("t3");
    check("t3_ct", ciphertext, CT1);
    @(negedge clk);

    // 4. Reset in the middle of RUN
    send("t4", KEY1, PT1);
    repeat (15) @(negedge clk);
    check("t4_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_in_ready",  in_ready,   1);
    check("t4_out_valid", out_valid,  0);
    check("t4_busy",      busy,       0);
    check("t4_ct_clear",  ciphertext, 0);
    send("t4b", KEY1, PT1);
    wait_valid("t4b");
    check("t4b_ct", ciphertext, CT1);
    @(negedge clk);

    // 5. Back-to-back with in_valid held high
    exp0      = simon_ref(64'd0, 32'd0);
    base      = out_cnt;
    acc1      = acc_cnt;
    key       = KEY1;
    plaintext = PT1;
    in_valid  = 1'b1;
    @(negedge clk);
    check("t5_first_accept", acc_cnt - acc1, 1);
    acc1      = last_acc;
    key       = 64'd0;
    plaintext = 32'd0;
    guard     = 0;
    while (acc_cnt < 2 + (out_cnt - out_cnt) + base - base + (acc_cnt - acc_cnt) + 0 &&
           guard < 0) guard++;
    guard = 0;
    while (last_acc == acc1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check("t5_accept_gap", last_acc - acc1, 34);
    wait_out("t5", base + 2, 1'b0);
    check("t5_ct0", out_q[base], CT1);
    check("t5_ct1", out_q[base+1], exp0);
    @(negedge clk);

    // 6. Random vectors with random output stalls
    for (int n = 0; n < 20; n++) begin
      rk   = {$urandom, $urandom};
      rp   = $urandom;
      base = out_cnt;
      send("t6", rk, rp);
      wait_out("t6", base + 1, 1'b1);
      check("t6_ct", out_q[base], simon_ref(rk, rp));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
